// File: rtl/fake_trigger_hls_deadlock_report_unit_if.sv
// Report-unit bus: monitor block inputs, clear, sticky deadlock flag and the valid/ready report record.
// Handshake: a report transfers on a rising edge where report_valid && report_ready; valid never drops without a transfer except on clear/reset.
interface fake_trigger_hls_deadlock_report_unit_if #(
  parameter int NUM_MONITORS = 4,
  parameter int IDX_W        = 2,
  parameter int CNT_W        = 32
);
  logic [NUM_MONITORS-1:0] monitor_block;
  logic                    clear;
  logic                    deadlock;
  logic                    report_valid;
  logic                    report_ready;
  logic [IDX_W-1:0]        report_idx;
  logic [NUM_MONITORS-1:0] report_mask;
  logic [CNT_W-1:0]        stall_cycles;
  logic [1:0]              dbg_state;

  modport master (
    output monitor_block, clear, report_ready,
    input  deadlock, report_valid, report_idx, report_mask, stall_cycles, dbg_state
  );

  modport slave (
    input  monitor_block, clear, report_ready,
    output deadlock, report_valid, report_idx, report_mask, stall_cycles, dbg_state
  );
endinterface

// File: rtl/fake_trigger_hls_deadlock_report_unit.sv
// Filters HLS monitor 'block' bits: declares a sticky deadlock after THRESHOLD consecutive blocked
// cycles, records the first blocker and a saturating stall count, and offers one report record.
module fake_trigger_hls_deadlock_report_unit #(
  parameter int NUM_MONITORS = 4,
  parameter int THRESHOLD    = 16,
  parameter int CNT_W        = 32,
  parameter int IDX_W        = 2
) (
  input  logic clock,
  input  logic reset,
  fake_trigger_hls_deadlock_report_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WATCH  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e                  state_q;
  logic                    deadlock_q;
  logic                    valid_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_MONITORS-1:0] mask_q;
  logic [CNT_W-1:0]        stall_q;

  logic                    any_block;
  logic [IDX_W-1:0]        low_idx_d;
  logic [CNT_W-1:0]        stall_inc_d;
  logic [CNT_W-1:0]        stall_sat_d;

  assign any_block = |bus.monitor_block;

  // Downward scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    low_idx_d = '0;
    for (int i = NUM_MONITORS - 1; i >= 0; i--) begin
      if (bus.monitor_block[i]) low_idx_d = IDX_W'(i);
    end
  end

  assign stall_inc_d = stall_q + CNT_W'(1);
  assign stall_sat_d = (stall_q == '1) ? stall_q : stall_inc_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      deadlock_q <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      mask_q     <= '0;
      stall_q    <= '0;
    end else if (bus.clear) begin
      // Clear beats detection and handshake; idx/mask remain for post-mortem reads.
      state_q    <= ST_IDLE;
      deadlock_q <= 1'b0;
      valid_q    <= 1'b0;
      stall_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_block) begin
            state_q <= ST_WATCH;
            stall_q <= CNT_W'(1);
            idx_q   <= low_idx_d;
          end
        end
        ST_WATCH: begin
          if (!any_block) begin
            state_q <= ST_IDLE;
            stall_q <= '0;
          end else begin
            stall_q <= stall_inc_d;
            if (stall_inc_d == CNT_W'(THRESHOLD)) begin
              state_q    <= ST_REPORT;
              deadlock_q <= 1'b1;
              valid_q    <= 1'b1;
              mask_q     <= bus.monitor_block;
            end
          end
        end
        ST_REPORT: begin
          if (any_block) stall_q <= stall_sat_d;
          if (bus.report_ready) begin
            state_q <= ST_HOLD;
            valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (any_block) stall_q <= stall_sat_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.deadlock     = deadlock_q;
  assign bus.report_valid = valid_q;
  assign bus.report_idx   = idx_q;
  assign bus.report_mask  = mask_q;
  assign bus.stall_cycles = stall_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_fake_trigger_hls_deadlock_report_unit.sv
// Bench for the deadlock report unit: directed scenarios plus random stimulus against a behavioural model.
module tb_fake_trigger_hls_deadlock_report_unit;
  localparam int NM   = 4;
  localparam int TH   = 4;
  localparam int CW   = 4;
  localparam int IW   = 2;
  localparam int SMAX = (1 << CW) - 1;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  fake_trigger_hls_deadlock_report_unit_if #(.NUM_MONITORS(NM), .IDX_W(IW), .CNT_W(CW)) bus ();

  fake_trigger_hls_deadlock_report_unit #(
    .NUM_MONITORS(NM), .THRESHOLD(TH), .CNT_W(CW), .IDX_W(IW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  bit           m_dl, m_valid, m_watch;
  int           m_stall;
  logic [IW-1:0] m_idx;
  logic [NM-1:0] m_mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] lowest(input logic [NM-1:0] b);
    for (int i = 0; i < NM; i++) if (b[i]) return IW'(i);
    return '0;
  endfunction

  task automatic model_reset();
    m_dl = 0; m_valid = 0; m_watch = 0; m_stall = 0; m_idx = '0; m_mask = '0;
  endtask

  task automatic model_edge(input logic [NM-1:0] blk, input logic clr, input logic rdy);
    if (clr) begin
      m_dl = 0; m_valid = 0; m_stall = 0; m_watch = 0;
    end else if (!m_dl) begin
      if (blk == '0) begin
        m_watch = 0; m_stall = 0;
      end else if (!m_watch) begin
        m_watch = 1; m_stall = 1; m_idx = lowest(blk);
      end else begin
        m_stall++;
        if (m_stall == TH) begin
          m_dl = 1; m_valid = 1; m_mask = blk;
        end
      end
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (blk != '0 && m_stall < SMAX) m_stall++;
    end
  endtask

  task automatic check_outputs();
    chk("deadlock", 32'(bus.deadlock),     32'(m_dl));
    chk("valid",    32'(bus.report_valid), 32'(m_valid));
    chk("stall",    32'(bus.stall_cycles), 32'(m_stall));
    chk("idx",      32'(bus.report_idx),   32'(m_idx));
    chk("mask",     32'(bus.report_mask),  32'(m_mask));
  endtask

  // driver: apply inputs, take one edge, compare 1 time unit after it
  task automatic step(input logic [NM-1:0] blk, input logic clr, input logic rdy);
    bus.monitor_block = blk;
    bus.clear         = clr;
    bus.report_ready  = rdy;
    @(posedge clock);
    model_edge(blk, clr, rdy);
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b0;
    bus.monitor_block = '0;
    bus.clear = 1'b0;
    bus.report_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_outputs();
    @(negedge clock);
    reset = 1'b1;

    // 1: single blocker, ready high, valid for exactly one cycle
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 1'b1);
    chk("t1_valid", 32'(bus.report_valid), 32'd1);
    chk("t1_idx",   32'(bus.report_idx),   32'd2);
    chk("t1_mask",  32'(bus.report_mask),  32'b0100);
    step(4'b0000, 1'b0, 1'b1);
    chk("t1_valid_drop", 32'(bus.report_valid), 32'd0);
    chk("t1_sticky",     32'(bus.deadlock),     32'd1);
    step(4'b0000, 1'b1, 1'b0);

    // 2: glitch restarts the count
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("t2_stall_zero", 32'(bus.stall_cycles), 32'd0);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b1);
    chk("t2_stall3", 32'(bus.stall_cycles), 32'd3);
    chk("t2_no_dl",  32'(bus.deadlock),     32'd0);
    step(4'b0000, 1'b0, 1'b0);

    // 3: back-pressured report stays stable
    for (int i = 0; i < 14; i++) step(4'b1010, 1'b0, 1'b0);
    chk("t3_valid", 32'(bus.report_valid), 32'd1);
    chk("t3_idx",   32'(bus.report_idx),   32'd1);
    chk("t3_mask",  32'(bus.report_mask),  32'b1010);
    chk("t3_stall", 32'(bus.stall_cycles), 32'd14);
    step(4'b1010, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0);

    // 4: saturation
    for (int i = 0; i < 40; i++) step(4'b1000, 1'b0, 1'b1);
    chk("t4_sat", 32'(bus.stall_cycles), 32'd15);
    chk("t4_dl",  32'(bus.deadlock),     32'd1);
    step(4'b0000, 1'b1, 1'b0);

    // 5: clear while valid, simultaneous block loses to clear
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b1);
    chk("t5_valid", 32'(bus.report_valid), 32'd0);
    chk("t5_dl",    32'(bus.deadlock),     32'd0);
    chk("t5_stall", 32'(bus.stall_cycles), 32'd0);
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b0);
    chk("t5_not_yet", 32'(bus.report_valid), 32'd0);
    step(4'b0100, 1'b0, 1'b0);
    chk("t5_redetect", 32'(bus.report_valid), 32'd1);

    // 6: async reset during REPORT, between edges
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6_dl",    32'(bus.deadlock),     32'd0);
    chk("t6_valid", 32'(bus.report_valid), 32'd0);
    chk("t6_stall", 32'(bus.stall_cycles), 32'd0);
    chk("t6_idx",   32'(bus.report_idx),   32'd0);
    chk("t6_mask",  32'(bus.report_mask),  32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(4'b1001, 1'b0, 1'b1);
    chk("t6_after", 32'(bus.report_valid), 32'd1);

    // random: bursty blocking, random ready, rare clears
    for (int n = 0; n < 2000; n++) begin
      logic [NM-1:0] blk;
      logic          clr, rdy;
      blk = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(blk, clr, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
